serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on accepted start.
REQ-006 b  input  WIDTH  operand B; captured on accepted start.
REQ-007 cin  input  1  carry-in; captured on accepted start.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  single-cycle pulse, high only in DONE state.
REQ-010 sum  output  WIDTH  registered result of a+b+cin, mod 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the addition.

Function
REQ-012 Block SHALL compute a+b+cin bit-serially, LSB first, one bit per clock, through one 1-bit full-adder instance.
REQ-013 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 at edge k: load A/B shift registers from a/b, carry flop <= cin, bit counter <= 0, state <= RUN.
REQ-015 IDLE with start=0: remain IDLE; no register changes.
REQ-016 Each RUN edge: full adder sees A[0], B[0], carry flop; s shifted into result shift register from MSB side; carry flop <= adder cout; A/B shift right one; counter +1.
REQ-017 RUN edge where counter = WIDTH-1 (the WIDTH-th RUN edge, edge k+WIDTH): sum <= final result shift register contents, cout <= adder cout, state <= DONE.
REQ-018 DONE lasts exactly one cycle, then IDLE unconditionally; done=1 during that cycle, so done asserts WIDTH+1 cycles after the edge accepting start.
REQ-019 start asserted in RUN or DONE SHALL be ignored, not queued; operands/cin not re-sampled.
REQ-020 sum and cout SHALL hold the last completed result, unchanged through IDLE and the following RUN, until the next DONE entry.
REQ-021 a, b, cin may change freely after the accepting edge without affecting the result in progress.
REQ-022 Counter width SHALL be $clog2(WIDTH); no wrap beyond WIDTH-1 reachable.
REQ-023 Back-to-back: a start held high continuously SHALL be accepted in the IDLE cycle after DONE, giving one result every WIDTH+2 cycles.

Reset
REQ-024 On reset=1 at a rising edge: state <= IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0, shift registers=0.
REQ-025 Reset SHALL override start and any in-progress RUN; an aborted addition produces no done pulse and does not update sum/cout.
REQ-026 The first start may be accepted on the first edge after reset deasserts.

Structure
REQ-027 Shared package adder_pkg SHALL hold the state typedef (IDLE, RUN, DONE) and the default-width constant ADDER_WIDTH = 8.
REQ-028 Exactly one sub-module: the existing structural one_bit_full_adder_structural, instantiated once; no behavioural "+" operator in this block.
REQ-029 Implementation SHALL be a registered FSM plus datapath registers; outputs busy/done decoded from state only.

Verification (WIDTH=8)
REQ-030 a=0x5A, b=0x3C, cin=0, start at edge k -> done high in cycle after edge k+8, sum=0x96, cout=0.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 Start 0x10+0x20; pulse start with a=0xFF, b=0xFF at edge k+3 -> ignored; result sum=0x30, cout=0, one done pulse only.
REQ-033 Complete 0x01+0x01 (sum=0x02); start 0x80+0x80; reset at edge k+4 -> no done, busy=0, sum=0x00, cout=0 next cycle.
REQ-034 start held high, operands 0x01+0x02 then 0x03+0x04 -> done pulses 10 cycles apart, sums 0x03 then 0x07; sum stable between pulses.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;
  localparam int ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/one_bit_full_adder_structural.sv
// Gate-level 1-bit full adder; the only arithmetic element of the serial adder.
module one_bit_full_adder_structural (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic ab_x, ab_a, c_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (s, ab_x, cin);
  and g_a0 (ab_a, a, b);
  and g_a1 (c_a, ab_x, cin);
  or  g_o0 (cout, ab_a, c_a);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: a+b+cin computed LSB first, one bit per clock, through a
// single full-adder cell, sequenced by a three-state IDLE/RUN/DONE FSM.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;

  one_bit_full_adder_structural u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {fa_s, res_sr[WIDTH-1:1]};
          carry  <= fa_c;
          if (cnt == CW'(WIDTH - 1)) begin
            // Last bit: publish the result including this edge's sum bit.
            sum   <= {fa_s, res_sr[WIDTH-1:1]};
            cout  <= fa_c;
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
